// File: rtl/apb_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// apb_ctrl_pkg
// Shared types and default widths for the APB master controller.
//   apb_state_t      : bus phase of the controller FSM (IDLE / SETUP / ACCESS)
//   DEF_NUM_REQ      : default number of requesters
//   DEF_ADDR_W       : default paddr width
//   DEF_DATA_W       : default pwdata/prdata width
//   DEF_TIMEOUT      : default ACCESS-phase watchdog limit (APB_TIMEOUT_EN builds)
// -----------------------------------------------------------------------------
package apb_ctrl_pkg;

   localparam int DEF_NUM_REQ = 2;
   localparam int DEF_ADDR_W  = 2;
   localparam int DEF_DATA_W  = 2;
   localparam int DEF_TIMEOUT = 16;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SETUP  = 2'd1,
      ACCESS = 2'd2
   } apb_state_t;

endpackage

// File: rtl/apb_rr_arbiter.sv
// -----------------------------------------------------------------------------
// apb_rr_arbiter
// Combinational round-robin pick. The search starts at last_gnt+1 and wraps,
// so the most recently served requester has the lowest priority.
// Ports:
//   req       in  NUM_REQ  request levels
//   last_gnt  in  IDX_W    index of the previously granted requester
//   gnt       out NUM_REQ  one-hot winner (all zero when no request)
//   gnt_idx   out IDX_W    binary index of the winner
//   gnt_valid out 1        at least one request present
// -----------------------------------------------------------------------------
module apb_rr_arbiter
   import apb_ctrl_pkg::*;
#(
   parameter  int NUM_REQ = DEF_NUM_REQ,
   localparam int IDX_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
   input  logic [NUM_REQ-1:0] req,
   input  logic [IDX_W-1:0]   last_gnt,
   output logic [NUM_REQ-1:0] gnt,
   output logic [IDX_W-1:0]   gnt_idx,
   output logic               gnt_valid
);

   // cand_idx[k] is the requester examined k-th in priority order.
   logic [IDX_W-1:0]   cand_idx [NUM_REQ];
   logic [NUM_REQ-1:0] cand_req;

   for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_cand
      assign cand_idx[gi] = IDX_W'((int'(last_gnt) + gi + 1) % NUM_REQ);
      assign cand_req[gi] = req[cand_idx[gi]];
   end

   // Scan from lowest priority to highest so the highest-priority hit wins.
   always_comb begin
      gnt       = '0;
      gnt_idx   = '0;
      gnt_valid = 1'b0;
      for (int k = NUM_REQ - 1; k >= 0; k--) begin
         if (cand_req[k]) begin
            gnt_idx   = cand_idx[k];
            gnt_valid = 1'b1;
         end
      end
      if (gnt_valid) begin
         gnt[gnt_idx] = 1'b1;
      end
   end

endmodule

// File: rtl/apb_master_ctrl.sv
// -----------------------------------------------------------------------------
// apb_master_ctrl
// APB master shared between NUM_REQ requesters with round-robin arbitration.
// Sequences SETUP/ACCESS toward the slave and routes the completion back to
// the requester that owned the transfer. All outputs are registered.
//
// Optional macro APB_TIMEOUT_EN: adds an ACCESS-phase watchdog that completes
// a stalled transfer with rsp_err=1 after TIMEOUT_CYCLES cycles without pready.
//
// Ports:
//   pclk, preset          clock, synchronous active-high reset
//   req/req_write         per-requester request level and direction
//   req_addr/req_wdata    per-requester command, requester i at [i*W +: W]
//   req_gnt               one-hot pulse: command captured (SETUP cycle)
//   rsp_valid             one-hot pulse: transfer complete
//   rsp_rdata/rsp_err     completion data/error, valid with rsp_valid
//   paddr/pselx/penable/pwrite/pwdata   APB command toward the slave
//   pready/prdata/pslave_error          APB response from the slave
// -----------------------------------------------------------------------------
module apb_master_ctrl
   import apb_ctrl_pkg::*;
#(
   parameter int NUM_REQ        = DEF_NUM_REQ,
   parameter int ADDR_W         = DEF_ADDR_W,
   parameter int DATA_W         = DEF_DATA_W,
   parameter int TIMEOUT_CYCLES = DEF_TIMEOUT
) (
   input  logic                       pclk,
   input  logic                       preset,
   input  logic [NUM_REQ-1:0]         req,
   input  logic [NUM_REQ-1:0]         req_write,
   input  logic [NUM_REQ*ADDR_W-1:0]  req_addr,
   input  logic [NUM_REQ*DATA_W-1:0]  req_wdata,
   output logic [NUM_REQ-1:0]         req_gnt,
   output logic [NUM_REQ-1:0]         rsp_valid,
   output logic [DATA_W-1:0]          rsp_rdata,
   output logic                       rsp_err,
   output logic [ADDR_W-1:0]          paddr,
   output logic                       pselx,
   output logic                       penable,
   output logic                       pwrite,
   output logic [DATA_W-1:0]          pwdata,
   input  logic                       pready,
   input  logic [DATA_W-1:0]          prdata,
   input  logic                       pslave_error
);

   localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

   apb_state_t         state_reg;
   logic [IDX_W-1:0]   last_gnt_reg;

   logic [NUM_REQ-1:0] arb_gnt;
   logic [IDX_W-1:0]   arb_idx;
   logic               arb_valid;

   logic [NUM_REQ-1:0] owner_onehot;
   logic               xfer_timeout;
   logic               xfer_done;

   apb_rr_arbiter #(
      .NUM_REQ (NUM_REQ)
   ) u_arb (
      .req       (req),
      .last_gnt  (last_gnt_reg),
      .gnt       (arb_gnt),
      .gnt_idx   (arb_idx),
      .gnt_valid (arb_valid)
   );

   // last_gnt always names the owner of the transfer in flight.
   for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_owner
      assign owner_onehot[gi] = (last_gnt_reg == IDX_W'(gi));
   end

`ifdef APB_TIMEOUT_EN
   localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);

   logic [TO_W-1:0] to_cnt_reg;

   // Counter holds the number of completed stalled ACCESS cycles; firing at
   // TIMEOUT_CYCLES-1 ends the transfer on the edge closing the last one.
   // A simultaneous pready takes priority.
   assign xfer_timeout = !pready && (to_cnt_reg == TO_W'(TIMEOUT_CYCLES - 1));

   always_ff @(posedge pclk) begin
      if (preset || state_reg != ACCESS) begin
         to_cnt_reg <= '0;
      end else if (!pready) begin
         to_cnt_reg <= to_cnt_reg + TO_W'(1);
      end
   end
`else
   assign xfer_timeout = 1'b0;
`endif

   // Only ACCESS can complete; pready during SETUP is ignored.
   assign xfer_done = (state_reg == ACCESS) && (pready || xfer_timeout);

   always_ff @(posedge pclk) begin
      if (preset) begin
         state_reg    <= IDLE;
         last_gnt_reg <= IDX_W'(NUM_REQ - 1);
         req_gnt      <= '0;
         rsp_valid    <= '0;
         rsp_rdata    <= '0;
         rsp_err      <= 1'b0;
         paddr        <= '0;
         pselx        <= 1'b0;
         penable      <= 1'b0;
         pwrite       <= 1'b0;
         pwdata       <= '0;
      end else begin
         req_gnt   <= '0;
         rsp_valid <= '0;

         // Completion response (uses the owner before last_gnt is updated).
         if (xfer_done) begin
            rsp_valid <= owner_onehot;
            rsp_rdata <= (pready && !pwrite) ? prdata : '0;
            rsp_err   <= pready ? pslave_error : 1'b1;
         end

         case (state_reg)
            IDLE, ACCESS: begin
               if (state_reg == IDLE || xfer_done) begin
                  if (arb_valid) begin
                     // Grant: capture the winner's command and enter SETUP.
                     state_reg    <= SETUP;
                     pselx        <= 1'b1;
                     penable      <= 1'b0;
                     paddr        <= req_addr[arb_idx*ADDR_W +: ADDR_W];
                     pwdata       <= req_wdata[arb_idx*DATA_W +: DATA_W];
                     pwrite       <= req_write[arb_idx];
                     req_gnt      <= arb_gnt;
                     last_gnt_reg <= arb_idx;
                  end else begin
                     // Command outputs keep their last values while idle.
                     state_reg <= IDLE;
                     pselx     <= 1'b0;
                     penable   <= 1'b0;
                  end
               end
            end
            SETUP: begin
               state_reg <= ACCESS;
               penable   <= 1'b1;
            end
            default: begin
               state_reg <= IDLE;
               pselx     <= 1'b0;
               penable   <= 1'b0;
            end
         endcase
      end
   end

endmodule
